lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store initiator between the MEM pipeline stage and DATA_MEM's byte-addressed port.
//  Accepts one RV32I load/store request at a time and drives mem_addr, mem_we and mem_wdata.
//  Sign- or zero-extends load data and returns it with a valid/ready response.
//  DATA_MEM always writes 4 bytes, so SB/SH are done as a two-cycle read-modify-write.
// PARAMETERS
//  MEM_BYTES    65536  memory size in bytes; an access with addr+size > MEM_BYTES is an error
//  CHECK_ALIGN  1      1: LH/LHU/SH need addr[0]==0, and LW/SW need addr[1:0]==0, else error
// PORTS
//  clk         in   1   clock; everything updates on the rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept a request (IDLE only)
//  req_store   in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (low byte / half used for SB/SH)
//  resp_valid  out  1   response present; held until resp_ready
//  resp_ready  in   1   consumer accepts the response
//  resp_rdata  out  32  extended load data (0 for stores and errors)
//  resp_err    out  1   misaligned, out-of-range or illegal funct3; no memory write was done
//  mem_addr    out  32  to DATA_MEM addr
//  mem_we      out  1   to DATA_MEM write_en
//  mem_wdata   out  32  to DATA_MEM write_data
//  mem_rdata   in   32  4 bytes at mem_addr, combinational, little-endian ({b3,b2,b1,b0})
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 from the first cycle after reset.
//   resp_valid, resp_err, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0.
//  Handshake: a request is accepted on the cycle where req_valid && req_ready.
//   On acceptance, store, funct3, addr and wdata are latched.
//   Request inputs are ignored outside IDLE.
//  FSM: IDLE, READ, WRITE, RESP, with this next-state after acceptance:
//   error (illegal funct3, misaligned when CHECK_ALIGN=1, or out of range)  -> RESP with resp_err=1
//   load                                                                  -> READ
//   SW                                                                    -> WRITE
//   SB/SH                                                                 -> READ
//  READ: mem_addr=latched addr, mem_we=0; mem_rdata is sampled at the clock edge.
//   Load: resp_rdata <= extended data.
//    LB: {{24{d[7]}},d[7:0]}      LBU: {24'b0,d[7:0]}
//    LH: {{16{d[15]}},d[15:0]}    LHU: {16'b0,d[15:0]}    LW: d
//    Next state: RESP.
//   SB/SH: merge register <= {d[31:8],wdata[7:0]} or {d[31:16],wdata[15:0]}; next state: WRITE.
//  WRITE: exactly one cycle. mem_we=1, mem_addr=latched addr.
//   mem_wdata = merge register (SB/SH) or latched wdata (SW). Next state: RESP.
//  RESP: resp_valid=1. When resp_ready=1 -> IDLE, and resp_valid drops the next cycle.
//   resp_valid, resp_rdata and resp_err hold steady while resp_ready=0.
//  mem_we is 1 only in WRITE. mem_addr holds its last value in IDLE and RESP.
//  Latency, from acceptance cycle T to the first cycle resp_valid=1:
//   load T+2, SW T+2, SB/SH T+3, error T+1.
//   A new request can be accepted in the cycle after the response handshake (no overlap).
//  Range check: size 1/2/4 bytes. addr=MEM_BYTES-4 with LW is legal; MEM_BYTES-3 with LW is an error.
//   The sum addr+size is computed 33 bits wide, so addr near 2^32 is an error (no wrap).
//  Reset mid-operation: go to IDLE at once and drop mem_we.
//   A WRITE cycle that coincides with rst still reaches memory that edge (DATA_MEM samples write_en).
//   The response is discarded.
//  Stores do not check what was read back; read data for SB/SH affects only the merge.
// TESTING
//  1. mem[0x100..0x103]=80 7F 12 34; LB @0x100 -> resp_rdata=0xFFFFFF80 at T+2.
//     LBU @0x100 -> 0x00000080. LH @0x100 -> 0x00007F80. LW @0x100 -> 0x34127F80.
//  2. SW 0xDEADBEEF @0x200 -> mem_we=1 only at T+1 with wdata 0xDEADBEEF.
//     LW @0x200 then returns 0xDEADBEEF.
//  3. mem[0x200] word=0xDEADBEEF; SB 0x55 @0x200 -> READ, then WRITE of 0xDEADBE55.
//     SH 0xA5A5 @0x202 -> WRITE 0xA5A5 into bytes 0x202/0x203; other bytes unchanged.
//  4. CHECK_ALIGN=1: LW @0x201 -> resp_err=1 at T+1 with no mem_we.
//     Same for funct3=011 and for LW @MEM_BYTES-2.
//  5. Hold resp_ready=0 for 5 cycles -> resp_valid/resp_rdata stable and req_ready=0.
//     Back-to-back requests are then served in order.
//  6. Assert rst during READ of an SB -> next cycle IDLE, req_ready=1, resp_valid=0.
//     No write to memory.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the MEM stage and DATA_MEM.
// Accepts one RV32I load/store at a time, drives DATA_MEM's byte-addressed
// port and returns extended load data with a valid/ready response.
// DATA_MEM always writes four bytes, so SB/SH are a read-modify-write.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_store, req_funct3    1 = store; RV32I funct3 selects size/extension
//   req_addr, req_wdata      byte address, store data
//   resp_valid / resp_ready  response handshake, response held until taken
//   resp_rdata, resp_err     extended load data; error flag (no write done)
//   mem_addr, mem_we         DATA_MEM address and write enable
//   mem_wdata, mem_rdata     DATA_MEM write data, combinational read data
module lsu_mem_ctrl #(
    parameter int unsigned MEM_BYTES   = 65536,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_next;
    logic        store_q;
    logic [2:0]  funct3_q;

    logic [2:0]  size;
    logic        f3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [32:0] end_addr;

    // Request decode: access size, legality, alignment and range.
    // The end address is 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        size  = '0;
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000:  begin size = 3'd1; f3_ok = 1'b1;       end
            3'b001:  begin size = 3'd2; f3_ok = 1'b1;       end
            3'b010:  begin size = 3'd4; f3_ok = 1'b1;       end
            3'b100:  begin size = 3'd1; f3_ok = !req_store; end
            3'b101:  begin size = 3'd2; f3_ok = !req_store; end
            default: ;
        endcase
        misaligned   = CHECK_ALIGN &&
                       (((size == 3'd2) && req_addr[0]) ||
                        ((size == 3'd4) && (req_addr[1:0] != 2'b00)));
        end_addr     = {1'b0, req_addr} + {30'b0, size};
        out_of_range = end_addr > 33'(MEM_BYTES);
        req_err      = !f3_ok || misaligned || out_of_range;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_store && (req_funct3[1:0] == 2'b10))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:  state_next = store_q ? WRITE : RESP;
            WRITE: begin
                mem_we     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // mem_addr is only loaded for legal requests so it keeps its previous value
    // through an error response. mem_wdata doubles as the merge register: it
    // holds the latched store data, and for SB/SH its upper bytes are replaced
    // by the read data during READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q    <= 1'b0;
            funct3_q   <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    store_q    <= req_store;
                    funct3_q   <= req_funct3;
                    resp_err   <= req_err;
                    resp_rdata <= '0;
                    if (!req_err) begin
                        mem_addr <= req_addr;
                        if (req_store) mem_wdata <= req_wdata;
                    end
                end
                READ: begin
                    if (store_q) begin
                        if (funct3_q[0]) mem_wdata <= {mem_rdata[31:16], mem_wdata[15:0]};
                        else             mem_wdata <= {mem_rdata[31:8],  mem_wdata[7:0]};
                    end else begin
                        case (funct3_q)
                            3'b000:  resp_rdata <= {{24{mem_rdata[7]}},  mem_rdata[7:0]};
                            3'b001:  resp_rdata <= {{16{mem_rdata[15]}}, mem_rdata[15:0]};
                            3'b100:  resp_rdata <= {24'b0, mem_rdata[7:0]};
                            3'b101:  resp_rdata <= {16'b0, mem_rdata[15:0]};
                            default: resp_rdata <= mem_rdata;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl with a
// byte-array model of DATA_MEM (combinational read, 4-byte write).
module tb_lsu_mem_ctrl;

    localparam int unsigned MEM_BYTES = 65536;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_BYTES(MEM_BYTES), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // DATA_MEM model
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [15:0] a0, a1, a2, a3, p0, p1, p2, p3;
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = '0;
    logic [31:0] poke_data = '0;

    assign a0 = mem_addr[15:0];
    assign a1 = a0 + 16'd1;
    assign a2 = a0 + 16'd2;
    assign a3 = a0 + 16'd3;
    assign p0 = poke_addr[15:0];
    assign p1 = p0 + 16'd1;
    assign p2 = p0 + 16'd2;
    assign p3 = p0 + 16'd3;
    assign mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[a0] <= mem_wdata[7:0];
            mem[a1] <= mem_wdata[15:8];
            mem[a2] <= mem_wdata[23:16];
            mem[a3] <= mem_wdata[31:24];
        end
        if (poke_en) begin
            mem[p0] <= poke_data[7:0];
            mem[p1] <= poke_data[15:8];
            mem[p2] <= poke_data[23:16];
            mem[p3] <= poke_data[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = addr; poke_data = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // One transaction: issue, watch latency and writes, optionally stall the
    // response for `hold` cycles, then complete the handshake.
    task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int unsigned exp_lat, input logic [31:0] exp_rdata,
                       input logic exp_err, input int unsigned exp_we_at,
                       input logic [31:0] exp_wdata, input int unsigned hold);
        int unsigned lat, we_cnt, we_at;
        logic [31:0] we_data, we_addr;
        @(negedge clk);
        check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; we_cnt = 0; we_at = 0; we_data = '0; we_addr = '0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_we) begin
                we_cnt++; we_at = k; we_data = mem_wdata; we_addr = mem_addr;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":rdata"}, resp_rdata, exp_rdata);
        check({tag, ":err"}, 32'(resp_err), 32'(exp_err));
        check({tag, ":we_count"}, we_cnt, (exp_we_at != 0) ? 32'd1 : 32'd0);
        if (exp_we_at != 0) begin
            check({tag, ":we_cycle"}, we_at, exp_we_at);
            check({tag, ":we_data"}, we_data, exp_wdata);
            check({tag, ":we_addr"}, we_addr, addr);
        end
        if (!exp_err) check({tag, ":mem_addr_resp"}, mem_addr, addr);
        for (int h = 0; h < int'(hold); h++) begin
            // Requests offered while busy must be ignored.
            req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
            req_addr = 32'h300; req_wdata = 32'hBAD0BAD0;
            @(negedge clk);
            check({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ":hold_rdata"}, resp_rdata, exp_rdata);
            check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, ":hold_we"}, 32'(mem_we), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, ":resp_drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned we_seen;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        poke_word(32'h100,  32'h34127F80);
        poke_word(32'h200,  32'h00000000);
        poke_word(32'h204,  32'h0000CAFE);
        poke_word(32'h300,  32'h11223344);
        poke_word(32'hFFFC, 32'h9A000000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst:req_ready",  32'(req_ready), 32'd1);
        check("rst:resp_valid", 32'(resp_valid), 32'd0);
        check("rst:resp_err",   32'(resp_err), 32'd0);
        check("rst:mem_we",     32'(mem_we), 32'd0);
        check("rst:resp_rdata", resp_rdata, 32'd0);
        check("rst:mem_addr",   mem_addr, 32'd0);
        check("rst:mem_wdata",  mem_wdata, 32'd0);

        // Loads with extension
        txn("lb",  1'b0, 3'b000, 32'h100, '0, 2, 32'hFFFFFF80, 1'b0, 0, '0, 0);
        txn("lbu", 1'b0, 3'b100, 32'h100, '0, 2, 32'h00000080, 1'b0, 0, '0, 0);
        txn("lh",  1'b0, 3'b001, 32'h100, '0, 2, 32'h00007F80, 1'b0, 0, '0, 0);
        txn("lhu", 1'b0, 3'b101, 32'h102, '0, 2, 32'h00003412, 1'b0, 0, '0, 0);
        txn("lw",  1'b0, 3'b010, 32'h100, '0, 2, 32'h34127F80, 1'b0, 0, '0, 0);

        // Stores
        txn("sw",   1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 2, '0, 1'b0, 1, 32'hDEADBEEF, 0);
        txn("lw_sw",1'b0, 3'b010, 32'h200, '0, 2, 32'hDEADBEEF, 1'b0, 0, '0, 0);
        txn("sb",   1'b1, 3'b000, 32'h200, 32'hAAAAAA55, 3, '0, 1'b0, 2, 32'hDEADBE55, 0);
        txn("sh",   1'b1, 3'b001, 32'h202, 32'h1234A5A5, 3, '0, 1'b0, 2, 32'hCAFEA5A5, 0);
        txn("lw_sh",1'b0, 3'b010, 32'h200, '0, 2, 32'hA5A5BE55, 1'b0, 0, '0, 0);
        txn("lw_hi",1'b0, 3'b010, 32'h204, '0, 2, 32'h0000CAFE, 1'b0, 0, '0, 0);

        // Errors and range boundaries
        txn("e_lw_mis", 1'b0, 3'b010, 32'h201, '0, 1, '0, 1'b1, 0, '0, 0);
        txn("e_f3_011", 1'b0, 3'b011, 32'h100, '0, 1, '0, 1'b1, 0, '0, 0);
        txn("e_lw_end", 1'b0, 3'b010, 32'hFFFE, '0, 1, '0, 1'b1, 0, '0, 0);
        txn("e_lh_mis", 1'b0, 3'b001, 32'h101, '0, 1, '0, 1'b1, 0, '0, 0);
        txn("e_sw_mis", 1'b1, 3'b010, 32'h202, 32'h0, 1, '0, 1'b1, 0, '0, 0);
        txn("e_st_f3",  1'b1, 3'b100, 32'h200, 32'h0, 1, '0, 1'b1, 0, '0, 0);
        txn("e_wrap",   1'b0, 3'b010, 32'hFFFFFFFC, '0, 1, '0, 1'b1, 0, '0, 0);
        txn("lw_last",  1'b0, 3'b010, 32'hFFFC, '0, 2, 32'h9A000000, 1'b0, 0, '0, 0);
        txn("lb_last",  1'b0, 3'b000, 32'hFFFF, '0, 2, 32'hFFFFFF9A, 1'b0, 0, '0, 0);
        txn("lw_noerr", 1'b0, 3'b010, 32'h200, '0, 2, 32'hA5A5BE55, 1'b0, 0, '0, 0);

        // Stalled response, then back-to-back requests
        txn("hold", 1'b0, 3'b010, 32'h100, '0, 2, 32'h34127F80, 1'b0, 0, '0, 5);
        txn("b2b1", 1'b0, 3'b000, 32'h103, '0, 2, 32'h00000034, 1'b0, 0, '0, 0);
        txn("b2b2", 1'b0, 3'b010, 32'h300, '0, 2, 32'h11223344, 1'b0, 0, '0, 0);

        // Reset during READ of an SB
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h300; req_wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid:req_ready",  32'(req_ready), 32'd1);
        check("rst_mid:resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mid:mem_we",     32'(mem_we), 32'd0);
        we_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_we || resp_valid) we_seen++;
        end
        check("rst_mid:quiet", we_seen, 32'd0);
        txn("rst_mid_lw", 1'b0, 3'b010, 32'h300, '0, 2, 32'h11223344, 1'b0, 0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
